// File: rtl/int8_mm_pkg.sv
// Shared types and helpers for the parametrised matrix-multiply engine:
// FSM state encoding, counter width helper and output conversion.
package int8_mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_A,
        ST_RECV_B,
        ST_COMPUTE,
        ST_SEND,
        ST_DONE
    } mm_state_t;

    // Working width of the conversion helper; accumulators are extended to this first.
    localparam int SAT_W   = 64;
    localparam int MAX_DIM = 32;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Clamp (sat_en=1) or pass through (sat_en=0) a signed/unsigned value for an
    // out_w-bit result; the caller keeps the low out_w bits of the return value.
    function automatic logic [SAT_W-1:0] sat_conv(input logic [SAT_W-1:0] value,
                                                 input logic is_signed,
                                                 input logic sat_en,
                                                 input int out_w);
        logic signed [SAT_W-1:0] smax;
        logic signed [SAT_W-1:0] smin;
        logic [SAT_W-1:0]        umax;
        smax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (out_w - 1));
        umax = (64'd1 << out_w) - 64'd1;
        if (!sat_en) begin
            return value;
        end
        if (is_signed) begin
            if ($signed(value) > smax) return smax;
            if ($signed(value) < smin) return smin;
            return value;
        end
        if (value > umax) return umax;
        return value;
    endfunction

endpackage

// File: rtl/int8_mac_row.sv
// One row of DIM parallel multiply-accumulators sharing a single A element;
// each MAC multiplies it by its own B element and accumulates modulo 2^ACC_W.
module int8_mac_row
    import int8_mm_pkg::*;
#(
    parameter int DIM   = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                        clk,
    input  logic                        ce,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        is_signed,
    input  logic [DW-1:0]               a_elem,
    input  logic [DIM-1:0][DW-1:0]      b_col,
    output logic [DIM-1:0][ACC_W-1:0]   acc
);

    logic signed [DW:0]       a_ext;
    logic signed [DW:0]       b_ext [DIM];
    logic signed [2*DW+1:0]   prod  [DIM];

    // One extra bit lets a single signed multiplier serve both operand modes.
    always_comb begin
        a_ext = {is_signed & a_elem[DW-1], a_elem};
        for (int j = 0; j < DIM; j++) begin
            b_ext[j] = {is_signed & b_col[j][DW-1], b_col[j]};
            prod[j]  = a_ext * b_ext[j];
        end
    end

    // Clear wins over everything so a reset or writeback always leaves clean accumulators.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DIM; j++) begin
            if (clr) begin
                acc[j] <= '0;
            end else if (ce && en) begin
                acc[j] <= acc[j] + ACC_W'(prod[j]);
            end
        end
    end

endmodule

// File: rtl/int8_mm_axis_param.sv
// DIMxDIM integer matrix multiply with AXI-Stream row/column I/O and
// ap_ctrl_chain handshaking; optional accumulation into the retained C buffer.
module int8_mm_axis_param
    import int8_mm_pkg::*;
#(
    parameter int DIM   = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_ce,
    input  logic                   ap_start,
    input  logic                   ap_continue,
    output logic                   ap_idle,
    output logic                   ap_ready,
    output logic                   ap_done,
    input  logic                   is_signed,
    input  logic                   accumulate,
    input  logic                   sat_en,
    input  logic [DIM*DW-1:0]      a_tdata,
    input  logic                   a_tvalid,
    output logic                   a_tready,
    input  logic [DIM*DW-1:0]      b_tdata,
    input  logic                   b_tvalid,
    output logic                   b_tready,
    output logic [DIM*OUT_W-1:0]   c_tdata,
    output logic                   c_tvalid,
    input  logic                   c_tready,
    output logic                   c_tlast
);

    localparam int ROW_W = cnt_w(DIM);
    localparam int K_W   = cnt_w(DIM + 1);

    if (DIM < 2 || DIM > MAX_DIM) begin : g_dim_chk
        $error("int8_mm_axis_param: DIM must be within 2..32");
    end
    if (ACC_W < 2*DW + $clog2(DIM) + 1 || ACC_W > SAT_W) begin : g_acc_chk
        $error("int8_mm_axis_param: ACC_W too narrow for DIM/DW or wider than 64");
    end
    if (OUT_W > ACC_W) begin : g_out_chk
        $error("int8_mm_axis_param: OUT_W must not exceed ACC_W");
    end

    mm_state_t               state;
    mm_state_t               state_next;
    logic [ROW_W-1:0]        row_cnt;
    logic [K_W-1:0]          k_cnt;
    logic [ROW_W-1:0]        k_idx;
    logic                    mode_signed;
    logic                    mode_acc;
    logic                    mode_sat;
    logic                    cbuf_valid;

    logic [DIM*DW-1:0]       a_buf [DIM];
    logic [DIM*DW-1:0]       b_buf [DIM];
    logic [ACC_W-1:0]        c_buf [DIM][DIM];

    logic                    a_hs;
    logic                    b_hs;
    logic                    c_hs;
    logic                    row_last;
    logic                    k_done;
    logic                    wb_cycle;
    logic                    mac_en;
    logic                    mac_clr;
    logic [DW-1:0]           a_elem;
    logic [DIM-1:0][DW-1:0]  b_col;
    logic [DIM-1:0][ACC_W-1:0] acc;

    logic [ROW_W-1:0]        conv_idx;
    logic [SAT_W-1:0]        conv_ext;
    logic [SAT_W-1:0]        conv_sat;
    logic [DIM*OUT_W-1:0]    conv_row;

    assign a_tready = ap_ce && (state == ST_RECV_A);
    assign b_tready = ap_ce && (state == ST_RECV_B);
    assign a_hs     = a_tvalid && a_tready;
    assign b_hs     = b_tvalid && b_tready;
    assign c_hs     = ap_ce && c_tvalid && c_tready;
    assign row_last = (row_cnt == ROW_W'(DIM - 1));
    assign k_done   = (k_cnt == K_W'(DIM));
    assign k_idx    = k_cnt[ROW_W-1:0];
    assign wb_cycle = (state == ST_COMPUTE) && k_done;
    assign mac_en   = (state == ST_COMPUTE) && !k_done;
    assign mac_clr  = ap_rst || (ap_ce && wb_cycle);

    assign ap_idle  = (state == ST_IDLE);
    assign ap_done  = (state == ST_DONE);
    assign ap_ready = b_hs && row_last;

    // Next-state decode; ap_start is only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (ap_start)           state_next = ST_RECV_A;
            ST_RECV_A:  if (a_hs && row_last)   state_next = ST_RECV_B;
            ST_RECV_B:  if (b_hs && row_last)   state_next = ST_COMPUTE;
            ST_COMPUTE: if (k_done && row_last) state_next = ST_SEND;
            ST_SEND:    if (c_hs && row_last)   state_next = ST_DONE;
            ST_DONE:    if (ap_continue)        state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else if (ap_ce) begin
            state <= state_next;
        end
    end

    // Step k of row i feeds A[i][k] against row k of B, i.e. element k of every column.
    always_comb begin
        a_elem = a_buf[row_cnt][k_idx*DW +: DW];
        for (int j = 0; j < DIM; j++) begin
            b_col[j] = b_buf[j][k_idx*DW +: DW];
        end
    end

    int8_mac_row #(
        .DIM   (DIM),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac_row (
        .clk       (ap_clk),
        .ce        (ap_ce),
        .clr       (mac_clr),
        .en        (mac_en),
        .is_signed (mode_signed),
        .a_elem    (a_elem),
        .b_col     (b_col),
        .acc       (acc)
    );

    // Output conversion looks one row ahead so the register can load on the accepting edge.
    always_comb begin
        conv_idx = (state == ST_SEND) ? row_cnt + 1'b1 : '0;
        conv_row = '0;
        conv_ext = '0;
        conv_sat = '0;
        for (int j = 0; j < DIM; j++) begin
            if (mode_signed) begin
                conv_ext = SAT_W'($signed(c_buf[conv_idx][j]));
            end else begin
                conv_ext = SAT_W'(c_buf[conv_idx][j]);
            end
            conv_sat = sat_conv(conv_ext, mode_signed, mode_sat, OUT_W);
            conv_row[j*OUT_W +: OUT_W] = conv_sat[OUT_W-1:0];
        end
    end

    // Buffers carry no reset; a reset simply blocks writes for that cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_ce && !ap_rst) begin
            if (a_hs) a_buf[row_cnt] <= a_tdata;
            if (b_hs) b_buf[row_cnt] <= b_tdata;
            if (wb_cycle) begin
                for (int j = 0; j < DIM; j++) begin
                    c_buf[row_cnt][j] <= acc[j] +
                        ((mode_acc && cbuf_valid) ? c_buf[row_cnt][j] : '0);
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            row_cnt     <= '0;
            k_cnt       <= '0;
            mode_signed <= 1'b0;
            mode_acc    <= 1'b0;
            mode_sat    <= 1'b0;
            cbuf_valid  <= 1'b0;
            c_tvalid    <= 1'b0;
            c_tlast     <= 1'b0;
            c_tdata     <= '0;
        end else if (ap_ce) begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        mode_signed <= is_signed;
                        mode_acc    <= accumulate;
                        mode_sat    <= sat_en;
                        row_cnt     <= '0;
                        k_cnt       <= '0;
                    end
                end
                ST_RECV_A: begin
                    if (a_hs) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end
                ST_RECV_B: begin
                    if (b_hs) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end
                ST_COMPUTE: begin
                    if (k_done) begin
                        k_cnt   <= '0;
                        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                        if (row_last) begin
                            cbuf_valid <= 1'b1;
                            c_tvalid   <= 1'b1;
                            c_tlast    <= 1'b0;
                            c_tdata    <= conv_row;
                        end
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (c_hs) begin
                        if (row_last) begin
                            c_tvalid <= 1'b0;
                            c_tlast  <= 1'b0;
                            row_cnt  <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                            c_tdata <= conv_row;
                            c_tlast <= (row_cnt == ROW_W'(DIM - 2));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
